// File: rtl/keypad_scanner.sv
// Keypad front end for the digital lock: scans a 4x4 hex matrix plus a
// dedicated ENTER button, synchronises and debounces whole scan frames,
// rejects multi-key presses and emits one strobed 5-bit code per press.
// Codes 0-15 are hex digits (4*row + column), code 16 is ENTER.
module keypad_scanner #(
  parameter int unsigned SCAN_DIV = 10, // clocks per column slot, >= 4
  parameter int unsigned DEBOUNCE = 3   // identical frames needed to accept, >= 1
) (
  input  logic       clk,
  input  logic       rst,       // asynchronous, active low
  input  logic [3:0] row,       // active-low row sense, asynchronous
  input  logic       enter_btn, // active-high, asynchronous
  output logic [3:0] col,       // active-low one-hot column drive
  output logic [4:0] keyout,
  output logic       strobe,
  output logic       key_held
);

  localparam int unsigned SlotW = (SCAN_DIV > 1) ? $clog2(SCAN_DIV) : 1;
  localparam int unsigned CntW  = $clog2(DEBOUNCE + 1);

  localparam logic [SlotW-1:0] SlotLast = SlotW'(SCAN_DIV - 1);
  localparam logic [CntW-1:0]  CntMax   = CntW'(DEBOUNCE);

  // Classification of one complete scan frame.
  typedef enum logic [1:0] {
    ResNone  = 2'd0,
    ResKey   = 2'd1,
    ResMulti = 2'd2
  } res_kind_e;

  typedef enum logic {
    StIdle = 1'b0,
    StHeld = 1'b1
  } state_e;

  // Synchronisers
  logic [3:0] row_meta_q, row_sync_q;
  logic       enter_meta_q, enter_sync_q;

  // Scan timing
  logic [SlotW-1:0] slot_q;
  logic [1:0]       col_q;
  logic             slot_last;
  logic             frame_end;

  // Frame snapshot: bits [4r+c] are matrix keys, bit 16 is ENTER (1 = pressed)
  logic [16:0] snap_q;
  logic [16:0] frame_bits;

  // Frame result and debounce
  res_kind_e       res_kind;
  logic [4:0]      res_code;
  res_kind_e       prev_kind_q;
  logic [4:0]      prev_code_q;
  logic            res_same;
  logic [CntW-1:0] cnt_q, cnt_d;
  logic            res_stable;

  state_e state_q;

  // Two-flop synchronisers; rows idle high so a reset never looks like a press.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      row_meta_q   <= 4'hF;
      row_sync_q   <= 4'hF;
      enter_meta_q <= 1'b0;
      enter_sync_q <= 1'b0;
    end else begin
      row_meta_q   <= row;
      row_sync_q   <= row_meta_q;
      enter_meta_q <= enter_btn;
      enter_sync_q <= enter_meta_q;
    end
  end

  assign slot_last = (slot_q == SlotLast);
  assign frame_end = slot_last && (col_q == 2'd3);

  // Slot and column counters wrap freely.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      slot_q <= '0;
      col_q  <= 2'd0;
    end else if (slot_last) begin
      slot_q <= '0;
      col_q  <= col_q + 2'd1;
    end else begin
      slot_q <= slot_q + SlotW'(1);
    end
  end

  // Decode the active column into an active-low one-hot drive.
  always_comb begin
    col        = 4'hF;
    col[col_q] = 1'b0;
  end

  // Merge the samples taken this clock into the snapshot so the frame result
  // can be formed on the same clock as the final column-3 sample.
  always_comb begin
    frame_bits = snap_q;
    if (slot_last) begin
      for (int r = 0; r < 4; r++) begin
        frame_bits[{1'b0, 2'(r), col_q}] = ~row_sync_q[2'(r)];
      end
      if (col_q == 2'd3) begin
        frame_bits[16] = enter_sync_q;
      end
    end
  end

  // Snapshot register; every bit is rewritten once per frame.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      snap_q <= '0;
    end else begin
      snap_q <= frame_bits;
    end
  end

  // Classify the frame: none, exactly one key (with its code), or several.
  always_comb begin
    res_kind = ResNone;
    res_code = 5'd0;
    for (int i = 0; i < 17; i++) begin
      if (frame_bits[5'(i)]) begin
        if (res_kind == ResNone) begin
          res_kind = ResKey;
          res_code = 5'(i);
        end else begin
          res_kind = ResMulti;
        end
      end
    end
    // All multi-key frames compare equal to one another.
    if (res_kind == ResMulti) begin
      res_code = 5'd0;
    end
  end

  assign res_same = (res_kind == prev_kind_q) && (res_code == prev_code_q);

  // Debounce count: restart on any change of result, saturate at DEBOUNCE.
  always_comb begin
    if (!res_same) begin
      cnt_d = CntW'(1);
    end else if (cnt_q == CntMax) begin
      cnt_d = cnt_q;
    end else begin
      cnt_d = cnt_q + CntW'(1);
    end
  end

  assign res_stable = (cnt_d == CntMax);

  // Remember the previous frame result and its run length.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      prev_kind_q <= ResNone;
      prev_code_q <= 5'd0;
      cnt_q       <= '0;
    end else if (frame_end) begin
      prev_kind_q <= res_kind;
      prev_code_q <= res_code;
      cnt_q       <= cnt_d;
    end
  end

  // Press/release FSM with registered outputs; acts only at frame end.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q  <= StIdle;
      keyout   <= 5'd0;
      strobe   <= 1'b0;
      key_held <= 1'b0;
    end else begin
      strobe <= 1'b0;
      if (frame_end) begin
        unique case (state_q)
          StIdle: begin
            if (res_stable && (res_kind == ResKey)) begin
              state_q  <= StHeld;
              keyout   <= res_code;
              strobe   <= 1'b1;
              key_held <= 1'b1;
            end
          end
          StHeld: begin
            // Only a stable empty frame counts as release; a new key or a
            // multi-press while held is ignored, so nothing auto-repeats.
            if (res_stable && (res_kind == ResNone)) begin
              state_q  <= StIdle;
              key_held <= 1'b0;
            end
          end
          default: state_q <= StIdle;
        endcase
      end
    end
  end

endmodule

// File: tb/tb_keypad_scanner.sv
// Self-checking bench for keypad_scanner with SCAN_DIV=4, DEBOUNCE=3
// (one frame = 16 clocks). A small keypad model pulls rows low for pressed
// keys in the driven column; phases are applied on frame boundaries.
module tb_keypad_scanner;

  localparam int unsigned ScanDiv  = 4;
  localparam int unsigned Debounce = 3;
  localparam int Frame = 4 * ScanDiv;

  logic       clk;
  logic       rst;
  logic [3:0] row;
  logic       enter_btn;
  logic [3:0] col;
  logic [4:0] keyout;
  logic       strobe;
  logic       key_held;

  logic [15:0] keys;  // pressed matrix keys, bit 4r+c

  int n_checks = 0;
  int n_fail   = 0;
  int cyc;
  int strobe_count = 0;
  int last_strobe_cyc = -1;
  int s0;

  typedef struct {
    logic [15:0] keys;
    logic        ent;
    int          frames;
    int          strobes;
    int          code;
    logic        held;
  } vec_t;

  localparam int NVec = 23;
  vec_t tbl [NVec];

  keypad_scanner #(
    .SCAN_DIV(ScanDiv),
    .DEBOUNCE(Debounce)
  ) dut (
    .clk      (clk),
    .rst      (rst),
    .row      (row),
    .enter_btn(enter_btn),
    .col      (col),
    .keyout   (keyout),
    .strobe   (strobe),
    .key_held (key_held)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Keypad matrix: a pressed key shorts its row to the driven (low) column.
  always_comb begin
    row = 4'hF;
    for (int r = 0; r < 4; r++) begin
      for (int c = 0; c < 4; c++) begin
        if (keys[4*r+c] && !col[c]) row[r] = 1'b0;
      end
    end
  end

  // Clocks since reset release.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) cyc <= 0;
    else      cyc <= cyc + 1;
  end

  // Strobe monitor, sampled just after each rising edge.
  always begin
    @(posedge clk);
    #1;
    if (strobe) begin
      strobe_count    = strobe_count + 1;
      last_strobe_cyc = cyc;
    end
  end

  task automatic chk(input string name, input int act, input int exp);
    n_checks++;
    if (act != exp) begin
      n_fail++;
      $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic step(input int n);
    repeat (n) @(posedge clk);
    #2;
  endtask

  initial begin
    //            keys      ent  frm stb code held
    tbl[0]  = '{16'h0200, 1'b0, 1, 0, 9,  1'b0}; // bounce: present
    tbl[1]  = '{16'h0000, 1'b0, 1, 0, 9,  1'b0}; // bounce: absent
    tbl[2]  = '{16'h0200, 1'b0, 1, 0, 9,  1'b0}; // stable run starts
    tbl[3]  = '{16'h0200, 1'b0, 1, 0, 9,  1'b0};
    tbl[4]  = '{16'h0200, 1'b0, 1, 1, 9,  1'b1}; // third frame: strobe
    tbl[5]  = '{16'h0200, 1'b0, 3, 0, 9,  1'b1}; // no auto-repeat
    tbl[6]  = '{16'h0000, 1'b0, 3, 0, 9,  1'b0}; // release
    tbl[7]  = '{16'h0000, 1'b1, 4, 1, 16, 1'b1}; // ENTER
    tbl[8]  = '{16'h0000, 1'b0, 3, 0, 16, 1'b0};
    tbl[9]  = '{16'h0001, 1'b0, 3, 1, 0,  1'b1}; // key 0
    tbl[10] = '{16'h0000, 1'b0, 3, 0, 0,  1'b0};
    tbl[11] = '{16'h0060, 1'b0, 6, 0, 0,  1'b0}; // keys 5+6: multi
    tbl[12] = '{16'h0020, 1'b0, 2, 0, 0,  1'b0}; // release 6
    tbl[13] = '{16'h0020, 1'b0, 1, 1, 5,  1'b1};
    tbl[14] = '{16'h0000, 1'b0, 3, 0, 5,  1'b0};
    tbl[15] = '{16'h0002, 1'b0, 3, 1, 1,  1'b1}; // key 1
    tbl[16] = '{16'h0004, 1'b0, 5, 0, 1,  1'b1}; // swap to 2 while held
    tbl[17] = '{16'h0006, 1'b0, 2, 0, 1,  1'b1}; // multi while held
    tbl[18] = '{16'h0000, 1'b0, 3, 0, 1,  1'b0};
    tbl[19] = '{16'h8000, 1'b0, 2, 0, 1,  1'b0}; // too short
    tbl[20] = '{16'h0000, 1'b0, 3, 0, 1,  1'b0};
    tbl[21] = '{16'h0010, 1'b1, 4, 0, 1,  1'b0}; // ENTER + key 4: multi
    tbl[22] = '{16'h0000, 1'b0, 3, 0, 1,  1'b0};

    rst       = 1'b0;
    keys      = 16'h0000;
    enter_btn = 1'b0;

    // Reset values.
    #20;
    chk("reset_col", int'(col), 4'b1110);
    chk("reset_keyout", int'(keyout), 0);
    chk("reset_strobe", int'(strobe), 0);
    chk("reset_key_held", int'(key_held), 0);
    #3;
    rst = 1'b1;

    // Column rotation, one slot every 4 clocks.
    step(4);
    chk("col_slot1", int'(col), 4'b1101);
    step(4);
    chk("col_slot2", int'(col), 4'b1011);
    step(4);
    chk("col_slot3", int'(col), 4'b0111);
    step(4);
    chk("col_wrap", int'(col), 4'b1110);

    // Key 9 (row2/col1) held from a frame start: strobe exactly 3 frames on.
    keys = 16'h0200;
    s0   = strobe_count;
    step(3 * Frame - 1);
    chk("lat_no_early_strobe", strobe_count, s0);
    step(1);
    chk("lat_strobe_count", strobe_count, s0 + 1);
    chk("lat_strobe_cycle", last_strobe_cyc, 16 + 3 * Frame);
    chk("lat_keyout", int'(keyout), 9);
    chk("lat_key_held", int'(key_held), 1);
    step(17 * Frame);
    chk("hold_20_frames_one_strobe", strobe_count, s0 + 1);
    keys = 16'h0000;
    step(3 * Frame - 1);
    chk("release_held_2_frames", int'(key_held), 1);
    step(1);
    chk("release_3_frames", int'(key_held), 0);
    chk("release_keyout_kept", int'(keyout), 9);

    // Table-driven phases, each starting on a frame boundary.
    for (int i = 0; i < NVec; i++) begin
      keys      = tbl[i].keys;
      enter_btn = tbl[i].ent;
      s0        = strobe_count;
      step(tbl[i].frames * Frame);
      chk($sformatf("vec%0d_strobes", i), strobe_count - s0, tbl[i].strobes);
      chk($sformatf("vec%0d_keyout", i), int'(keyout), tbl[i].code);
      chk($sformatf("vec%0d_key_held", i), int'(key_held), int'(tbl[i].held));
    end

    // Reset during the second debounce frame of key 3.
    keys = 16'h0008;
    enter_btn = 1'b0;
    s0 = strobe_count;
    step(Frame + 5);
    rst = 1'b0;
    #1;
    chk("midrst_col", int'(col), 4'b1110);
    chk("midrst_keyout", int'(keyout), 0);
    chk("midrst_strobe", int'(strobe), 0);
    chk("midrst_key_held", int'(key_held), 0);
    chk("midrst_no_strobe", strobe_count, s0);
    #20;
    @(negedge clk);
    rst = 1'b1;
    s0 = strobe_count;
    step(3 * Frame - 1);
    chk("postrst_no_early_strobe", strobe_count, s0);
    step(1);
    chk("postrst_strobe_count", strobe_count, s0 + 1);
    chk("postrst_strobe_cycle", last_strobe_cyc, 3 * Frame);
    chk("postrst_keyout", int'(keyout), 3);
    keys = 16'h0000;
    step(3 * Frame);
    chk("postrst_release", int'(key_held), 0);
    chk("postrst_single_strobe", strobe_count, s0 + 1);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/keypad_scanner.md
Name: keypad_scanner

Overview:
- Upstream stage of the digital lock FSM.
- Scans a 4x4 hex matrix keypad and one dedicated ENTER push-button, synchronises and debounces them, and rejects multi-key presses.
- Emits one 5-bit key code per physical press, with a single-cycle strobe. The lock FSM advances only on that strobe.
- Codes: 0-15 are hex digits; 16 is ENTER.

Parameters:
SCAN_DIV, 10, clocks per column slot (>= 4).
DEBOUNCE, 3, consecutive identical scan frames required to accept a press or a release (>= 1).

Ports:
clk  input  1  system clock
rst  input  1  asynchronous, active-low reset
row  input  4  keypad row sense, active-low, asynchronous to clk
enter_btn  input  1  ENTER button, active-high, asynchronous to clk
col  output  4  column drive, active-low one-hot
keyout  output  5  last accepted key code (0-15 digit, 16 ENTER)
strobe  output  1  one-cycle pulse: keyout is new this cycle
key_held  output  1  a key is accepted and not yet released

Behaviour:
- Reset (rst=0, async) forces: col=4'b1110, keyout=5'd0, strobe=0, key_held=0. All counters, synchronisers and the frame snapshot clear; state=IDLE.
- row and enter_btn each pass through a 2-flop synchroniser before any use.
- Scan timing:
  - Slot counter runs 0..SCAN_DIV-1.
  - Column index c steps 0,1,2,3,0... at each slot wrap; col drives bit c low.
  - Synchronised rows are sampled on the last clock of each slot, into snapshot bits [4r+c] for r=0..3.
  - ENTER is sampled on the last clock of the column-3 slot.
  - One frame = 4*SCAN_DIV clocks. The frame ends at the column-3 sample.
- Frame result, computed at frame end over the 17 snapshot bits:
  - NONE: zero keys asserted.
  - KEY(code): exactly one key asserted. Code = 4*r+c, or 16 for ENTER.
  - MULTI: two or more keys asserted. MULTI is never reported.
- Debounce counter (cnt):
  - At frame end: if the result equals the previous frame's result, cnt saturates-increments at DEBOUNCE; otherwise cnt=1.
  - A result is "stable" when cnt==DEBOUNCE.
- FSM (updates only at frame end):
  - IDLE: stable KEY(k) -> HELD, with keyout=k, strobe=1 for exactly the next clock, key_held=1. Any other result stays in IDLE.
  - HELD: stable NONE -> IDLE, key_held=0. Any other result, including a different KEY or MULTI, stays in HELD with no strobe.
- Latency:
  - A clean press reaches strobe one clock after the end of the DEBOUNCE-th consecutive frame containing it.
  - This excludes up to 2 clocks of synchroniser delay, which SCAN_DIV>=4 covers.
- Boundary rules:
  - At most one strobe per press; holding never auto-repeats.
  - keyout holds its value between strobes and across release.
  - A key already held when reset deasserts is reported after DEBOUNCE frames.
  - Counter wrap: slot and column counters wrap freely; cnt saturates.
  - Reset mid-debounce or mid-HELD aborts immediately; nothing is emitted for the interrupted press.
  - A press and release of different keys in the same frame is handled purely by that frame's result.

Test Plan:
- Parameters for all cases: SCAN_DIV=4, DEBOUNCE=3 (frame = 16 clocks).
- Reset -> col=1110, keyout=0, strobe=0, key_held=0. After release, col cycles 1110,1101,1011,0111 every 4 clocks.
- Hold row2/col1 low from frame start for 20 frames -> exactly one strobe, with keyout=9, at clock 3*16+1 (±2 sync). key_held=1 until 3 NONE frames after release.
- Bounce: key 9 present, absent, present for one frame each, then held -> single strobe with keyout=9, 3 frames after the final stable start. No strobe during the bounce.
- enter_btn=1 held 4 frames -> strobe with keyout=16. Release then press row0/col0 -> second strobe with keyout=0.
- Keys 5 and 6 held together 6 frames -> no strobe. Release 6 (5 still held) -> strobe keyout=5 after 3 frames.
- rst pulsed low during the 2nd debounce frame of key 3 -> outputs return to reset values asynchronously. After rst release with key 3 still held -> strobe keyout=3 after 3 full frames.
